aukv_csr_unit: RTL and testbench

- Machine-mode CSR unit; successor to the fixed-address RV32I CSR file. Sits beside the execute stage.
- Serves CSRRW/CSRRS/CSRRC reads and writes, and performs trap entry and MRET state updates.
- Generates the interrupt request and trap/return targets for the fetch redirect.
- Adds parametrised width, 64-bit cycle/instret counters, vectored mtvec, interrupt pending/enable and illegal-access detection.

---
 rtl/aukv_csr_unit.sv | 172 +++++++++++++++++
 tb/tb_aukv_csr_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/aukv_csr_unit.sv
// Machine-mode CSR unit: CSRRW/S/C access, trap entry/MRET state updates,
// 64-bit cycle/instret counters, vectored mtvec and interrupt request logic.
module aukv_csr_unit #(
  parameter int              XLEN      = 32,
  parameter int              CNT_W     = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter int              HART_ID   = 0
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_csr_we,
  input  logic            i_csr_rd,
  input  logic [1:0]      i_csr_op,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  input  logic            i_trap_valid,
  input  logic            i_trap_is_irq,
  input  logic [4:0]      i_trap_cause,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_tval,
  input  logic            i_mret,
  input  logic            i_instr_retire,
  input  logic            i_irq_sw,
  input  logic            i_irq_timer,
  input  logic            i_irq_ext,
  output logic            o_irq_req,
  output logic [4:0]      o_irq_cause,
  output logic [XLEN-1:0] o_trap_target,
  output logic [XLEN-1:0] o_mepc
);
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA  = 12'h301, A_MIE    = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305, A_MSCR  = 12'h340, A_MEPC   = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342, A_MTVAL = 12'h343, A_MIP    = 12'h344;
  localparam logic [11:0] A_MCYC    = 12'hB00, A_MINS  = 12'hB02, A_MCYCH  = 12'hB80;
  localparam logic [11:0] A_MINSH   = 12'hB82, A_MHART = 12'hF14;
  localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(32'h0000_0888);
  localparam bit HI_OK = (CNT_W == 64);

  logic            r_mie_b, r_mpie_b;
  logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [CNT_W-1:0] r_mcycle, r_minstret;

  logic [XLEN-1:0] w_mstatus, w_mip, w_old, w_new, w_pend, w_base;
  logic [63:0]     w_cyc64, w_ins64, w_cyc_nxt, w_ins_nxt;
  logic            w_impl, w_ro, w_wen;

  // Counters viewed as 64 bits so high halves read 0 when CNT_W is 32
  assign w_cyc64 = 64'(r_mcycle);
  assign w_ins64 = 64'(r_minstret);
  assign w_mip   = XLEN'({i_irq_ext, 3'b000, i_irq_timer, 3'b000, i_irq_sw, 3'b000});

  // Address decode and current value of the addressed CSR
  always_comb begin
    w_mstatus     = '0;
    w_mstatus[3]  = r_mie_b;
    w_mstatus[7]  = r_mpie_b;
    w_mstatus[12:11] = 2'b11;
    w_impl = 1'b1;
    w_ro   = (i_csr_addr[11:10] == 2'b11);
    w_old  = '0;
    case (i_csr_addr)
      A_MSTATUS: w_old = w_mstatus;
      A_MISA:    begin w_old = XLEN'(32'h4000_0100); w_ro = 1'b1; end
      A_MIE:     w_old = r_mie;
      A_MTVEC:   w_old = r_mtvec;
      A_MSCR:    w_old = r_mscratch;
      A_MEPC:    w_old = r_mepc;
      A_MCAUSE:  w_old = r_mcause;
      A_MTVAL:   w_old = r_mtval;
      A_MIP:     begin w_old = w_mip; w_ro = 1'b1; end
      A_MCYC:    w_old = XLEN'(w_cyc64[31:0]);
      A_MINS:    w_old = XLEN'(w_ins64[31:0]);
      A_MCYCH:   w_old = XLEN'(w_cyc64[63:32]);
      A_MINSH:   w_old = XLEN'(w_ins64[63:32]);
      A_MHART:   w_old = XLEN'(HART_ID);
      default:   w_impl = 1'b0;
    endcase
  end

  // Illegal access, write enable and the read-modify-write result
  always_comb begin
    o_csr_illegal = (i_csr_rd | i_csr_we) &
                    (~w_impl | (i_csr_we & (i_csr_op != 2'd0) & w_ro));
    w_wen = i_csr_we & (i_csr_op != 2'd0) & ~o_csr_illegal;
    case (i_csr_op)
      2'd2:    w_new = w_old | i_csr_wdata;
      2'd3:    w_new = w_old & ~i_csr_wdata;
      default: w_new = i_csr_wdata;
    endcase
    o_csr_rdata = i_csr_rd ? w_old : '0;
  end

  // Counter next state: a write to either half replaces the increment
  always_comb begin
    w_cyc_nxt = w_cyc64 + 64'd1;
    if (w_wen && i_csr_addr == A_MCYC)
      w_cyc_nxt = {w_cyc64[63:32], w_new[31:0]};
    else if (w_wen && i_csr_addr == A_MCYCH && HI_OK)
      w_cyc_nxt = {w_new[31:0], w_cyc64[31:0]};
    w_ins_nxt = w_ins64 + 64'(i_instr_retire);
    if (w_wen && i_csr_addr == A_MINS)
      w_ins_nxt = {w_ins64[63:32], w_new[31:0]};
    else if (w_wen && i_csr_addr == A_MINSH && HI_OK)
      w_ins_nxt = {w_new[31:0], w_ins64[31:0]};
  end

  // Trap/MRET-owned state: trap beats MRET beats a CSR write
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mie_b  <= 1'b0;
      r_mpie_b <= 1'b0;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (i_trap_valid) begin
      r_mpie_b <= r_mie_b;
      r_mie_b  <= 1'b0;
      r_mepc   <= {i_trap_pc[XLEN-1:2], 2'b00};
      r_mcause <= {i_trap_is_irq, {(XLEN-6){1'b0}}, i_trap_cause};
      r_mtval  <= i_trap_tval;
    end else begin
      if (i_mret) begin
        r_mie_b  <= r_mpie_b;
        r_mpie_b <= 1'b1;
      end else if (w_wen && i_csr_addr == A_MSTATUS) begin
        r_mie_b  <= w_new[3];
        r_mpie_b <= w_new[7];
      end
      if (w_wen && i_csr_addr == A_MEPC)   r_mepc   <= {w_new[XLEN-1:2], 2'b00};
      if (w_wen && i_csr_addr == A_MCAUSE) r_mcause <= w_new;
      if (w_wen && i_csr_addr == A_MTVAL)  r_mtval  <= w_new;
    end
  end

  // Plain CSR-write-only registers and counters
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wen && i_csr_addr == A_MIE)  r_mie      <= w_new & IRQ_MASK;
      if (w_wen && i_csr_addr == A_MSCR) r_mscratch <= w_new;
      if (w_wen && i_csr_addr == A_MTVEC) begin
        r_mtvec[XLEN-1:2] <= w_new[XLEN-1:2];
        // reserved modes 2/3 keep the previous mode
        if (!w_new[1]) r_mtvec[1:0] <= w_new[1:0];
      end
      r_mcycle   <= CNT_W'(w_cyc_nxt);
      r_minstret <= CNT_W'(w_ins_nxt);
    end
  end

  // Trap target, return address and interrupt request
  always_comb begin
    w_base = {r_mtvec[XLEN-1:2], 2'b00};
    o_trap_target = w_base;
    if (r_mtvec[1:0] == 2'b01 && i_trap_is_irq)
      o_trap_target = w_base + XLEN'({i_trap_cause, 2'b00});
    o_mepc    = r_mepc;
    w_pend    = w_mip & r_mie;
    o_irq_req = r_mie_b & (|w_pend);
    if (w_pend[11])     o_irq_cause = 5'd11;
    else if (w_pend[3]) o_irq_cause = 5'd3;
    else if (w_pend[7]) o_irq_cause = 5'd7;
    else                o_irq_cause = 5'd0;
  end
endmodule

// File: tb/tb_aukv_csr_unit.sv
// Directed self-checking bench for aukv_csr_unit (MTVEC_RST = 0x100).
`timescale 1ns/1ps
module tb_aukv_csr_unit;
  logic        i_clk = 1'b0, i_rstn = 1'b0;
  logic        i_csr_we = 0, i_csr_rd = 0;
  logic [1:0]  i_csr_op = 0;
  logic [11:0] i_csr_addr = 0;
  logic [31:0] i_csr_wdata = 0;
  logic [31:0] o_csr_rdata;
  logic        o_csr_illegal;
  logic        i_trap_valid = 0, i_trap_is_irq = 0;
  logic [4:0]  i_trap_cause = 0;
  logic [31:0] i_trap_pc = 0, i_trap_tval = 0;
  logic        i_mret = 0, i_instr_retire = 0;
  logic        i_irq_sw = 0, i_irq_timer = 0, i_irq_ext = 0;
  logic        o_irq_req;
  logic [4:0]  o_irq_cause;
  logic [31:0] o_trap_target, o_mepc;

  int n_chk = 0, n_err = 0;
  logic [31:0] d, dh;

  aukv_csr_unit #(.XLEN(32), .CNT_W(64), .MTVEC_RST(32'h100), .HART_ID(0)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_csr_we(i_csr_we), .i_csr_rd(i_csr_rd), .i_csr_op(i_csr_op),
    .i_csr_addr(i_csr_addr), .i_csr_wdata(i_csr_wdata),
    .o_csr_rdata(o_csr_rdata), .o_csr_illegal(o_csr_illegal),
    .i_trap_valid(i_trap_valid), .i_trap_is_irq(i_trap_is_irq),
    .i_trap_cause(i_trap_cause), .i_trap_pc(i_trap_pc), .i_trap_tval(i_trap_tval),
    .i_mret(i_mret), .i_instr_retire(i_instr_retire),
    .i_irq_sw(i_irq_sw), .i_irq_timer(i_irq_timer), .i_irq_ext(i_irq_ext),
    .o_irq_req(o_irq_req), .o_irq_cause(o_irq_cause),
    .o_trap_target(o_trap_target), .o_mepc(o_mepc)
  );

  always #50 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  // combinational read in the low clock phase
  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    i_csr_rd = 1; i_csr_addr = a; #1;
    v = o_csr_rdata;
    i_csr_rd = 0;
  endtask

  // one write cycle: drive, cross the rising edge, release at the falling edge
  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v);
    i_csr_we = 1; i_csr_op = op; i_csr_addr = a; i_csr_wdata = v;
    @(negedge i_clk);
    i_csr_we = 0; i_csr_op = 0;
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    i_rstn = 1;
    @(negedge i_clk);

    // reset state
    rd(12'h305, d); chk("rst_mtvec", d, 32'h100);
    rd(12'h300, d); chk("rst_mstatus", d, 32'h1800);
    chk("rst_irq", o_irq_req, 1'b0);
    chk("rst_mepc", o_mepc, 32'h0);
    chk("rst_target", o_trap_target, 32'h100);
    i_csr_addr = 12'h305; #1; chk("rdata_no_rd", o_csr_rdata, 32'h0);

    // mscratch read-modify-write
    wr(12'h340, 2'd1, 32'hA5A5_0000); rd(12'h340, d); chk("scr_w", d, 32'hA5A5_0000);
    wr(12'h340, 2'd2, 32'h0000_00FF); rd(12'h340, d); chk("scr_s", d, 32'hA5A5_00FF);
    wr(12'h340, 2'd3, 32'hA500_0000); rd(12'h340, d); chk("scr_c", d, 32'h00A5_00FF);
    wr(12'h340, 2'd2, 32'h0);         rd(12'h340, d); chk("scr_s0", d, 32'h00A5_00FF);

    // vectored mtvec, interrupt trap, MRET
    wr(12'h305, 2'd1, 32'h1001); rd(12'h305, d); chk("mtvec", d, 32'h1001);
    wr(12'h300, 2'd2, 32'h8);    rd(12'h300, d); chk("mie_set", d, 32'h1808);
    i_trap_valid = 1; i_trap_is_irq = 1; i_trap_cause = 5'd7;
    i_trap_pc = 32'h3002; i_trap_tval = 32'h55; #1;
    chk("tgt_irq7", o_trap_target, 32'h101C);
    @(negedge i_clk);
    i_trap_valid = 0;
    rd(12'h342, d); chk("mcause", d, 32'h8000_0007);
    rd(12'h300, d); chk("trap_mstatus", d, 32'h1880);
    chk("trap_mepc", o_mepc, 32'h3000);
    rd(12'h343, d); chk("mtval", d, 32'h55);
    i_mret = 1; @(negedge i_clk); i_mret = 0;
    rd(12'h300, d); chk("mret_mstatus", d, 32'h1888);
    i_trap_is_irq = 0; i_trap_cause = 5'd2; #1;
    chk("tgt_exc2", o_trap_target, 32'h1000);
    wr(12'h305, 2'd1, 32'h2002); rd(12'h305, d); chk("mtvec_mode2", d, 32'h2001);

    // interrupt request and priority
    wr(12'h304, 2'd1, 32'hFFFF_FFFF); rd(12'h304, d); chk("mie_mask", d, 32'h888);
    i_irq_timer = 1; i_irq_ext = 1; #1;
    chk("irq_req", o_irq_req, 1'b1);
    chk("irq_cause11", o_irq_cause, 5'd11);
    rd(12'h344, d); chk("mip", d, 32'h880);
    i_irq_ext = 0; #1; chk("irq_cause7", o_irq_cause, 5'd7);
    i_irq_sw = 1; #1;  chk("irq_cause3", o_irq_cause, 5'd3);
    wr(12'h300, 2'd3, 32'h8);
    chk("irq_off", o_irq_req, 1'b0);
    i_irq_sw = 0; i_irq_timer = 0; #1;
    chk("irq_none", o_irq_cause, 5'd0);

    // cycle counter carry and write-over-increment
    @(negedge i_clk);
    wr(12'hB00, 2'd1, 32'hFFFF_FFFE);
    wr(12'hB80, 2'd1, 32'h0);
    repeat (3) @(negedge i_clk);
    rd(12'hB80, dh); rd(12'hB00, d);
    chk("mcycle_carry", {dh, d}, 64'h1_0000_0001);
    wr(12'hB00, 2'd1, 32'h55);
    rd(12'hB00, d); chk("mcycle_wr", d, 32'h55);
    rd(12'hB80, d); chk("mcycleh_hold", d, 32'h1);

    // minstret counts only retirements
    i_instr_retire = 1; repeat (5) @(negedge i_clk); i_instr_retire = 0;
    @(negedge i_clk);
    rd(12'hB02, d); chk("minstret", d, 32'h5);

    // illegal accesses and trap-over-write
    i_csr_we = 1; i_csr_op = 2'd1; i_csr_addr = 12'hF14; i_csr_wdata = 32'h77; #1;
    chk("ill_ro_wr", o_csr_illegal, 1'b1);
    @(negedge i_clk); i_csr_we = 0; i_csr_op = 0;
    rd(12'hF14, d); chk("hartid", d, 32'h0);
    i_csr_rd = 1; i_csr_addr = 12'h7C0; #1;
    chk("ill_unimpl", o_csr_illegal, 1'b1);
    i_csr_rd = 0;
    i_csr_we = 1; i_csr_op = 2'd0; i_csr_addr = 12'hF14; #1;
    chk("op0_ro_ok", o_csr_illegal, 1'b0);
    i_csr_we = 0;
    i_csr_we = 1; i_csr_op = 2'd1; i_csr_addr = 12'h301; i_csr_wdata = 0; #1;
    chk("ill_misa", o_csr_illegal, 1'b1);
    @(negedge i_clk); i_csr_we = 0; i_csr_op = 0;
    rd(12'h301, d); chk("misa", d, 32'h4000_0100);
    i_trap_valid = 1; i_trap_pc = 32'h204;
    wr(12'h341, 2'd1, 32'h40);
    i_trap_valid = 0;
    chk("trap_over_wr", o_mepc, 32'h204);

    // asynchronous reset mid-operation
    #10 i_rstn = 0; #1;
    rd(12'h340, d); chk("arst_scr", d, 32'h0);
    chk("arst_target", o_trap_target, 32'h100);
    chk("arst_mepc", o_mepc, 32'h0);
    @(negedge i_clk); i_rstn = 1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
